// File: rtl/reset_sequencer_if.sv
// Reset-sequencer signal bundle: PLL lock, per-channel re-reset requests and sequenced outputs.
// event_count is carried only when RESET_SEQ_EVENT_COUNT_EN is defined.
interface reset_sequencer_if #(
  parameter int unsigned CHANNELS = 4
);
  logic                locked;
  logic [CHANNELS-1:0] request;
  logic [CHANNELS-1:0] reset_out;
  logic                ready;
  logic [4:0]          stage;
`ifdef RESET_SEQ_EVENT_COUNT_EN
  logic [7:0]          event_count;

  modport master (
    input  locked,
    input  request,
    output reset_out,
    output ready,
    output stage,
    output event_count
  );

  modport slave (
    output locked,
    output request,
    input  reset_out,
    input  ready,
    input  stage,
    input  event_count
  );
`else
  modport master (
    input  locked,
    input  request,
    output reset_out,
    output ready,
    output stage
  );

  modport slave (
    output locked,
    output request,
    input  reset_out,
    input  ready,
    input  stage
  );
`endif
endinterface

// File: rtl/reset_sequencer.sv
// Releases CHANNELS reset domains in index order after PLL lock, with per-stage delays and
// partial re-reset requests. Optional debug event counter under RESET_SEQ_EVENT_COUNT_EN.
module reset_sequencer #(
  parameter real         CLOCK_FREQUENCY  = 2.5e6,
  parameter int unsigned CHANNELS         = 4,
  parameter int unsigned INITIAL_DELAY_US = 1000,
  parameter int unsigned STEP_DELAY_US    = 100,
  parameter int unsigned LOCK_FILTER      = 16
) (
  input logic               clk,
  input logic               rst,
  reset_sequencer_if.master bus
);

  localparam int InitRaw = $rtoi(CLOCK_FREQUENCY * INITIAL_DELAY_US / 1.0e6);
  localparam int StepRaw = $rtoi(CLOCK_FREQUENCY * STEP_DELAY_US / 1.0e6);
  localparam int InitCyc = (InitRaw < 1) ? 1 : InitRaw;
  localparam int StepCyc = (StepRaw < 1) ? 1 : StepRaw;
  localparam int MaxCyc  = (InitCyc > StepCyc) ? InitCyc : StepCyc;
  localparam int CntW    = $clog2(MaxCyc + 1);
  localparam int FiltW   = $clog2(LOCK_FILTER + 1);

  localparam logic [CntW-1:0]  InitLast = CntW'(InitCyc - 1);
  localparam logic [CntW-1:0]  StepLast = CntW'(StepCyc - 1);
  localparam logic [FiltW-1:0] FiltLast = FiltW'(LOCK_FILTER - 1);
  localparam logic [4:0]       LastStg  = 5'(CHANNELS - 1);

  typedef enum logic [1:0] {StHold, StInit, StStep, StRun} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [FiltW-1:0]    filt_q, filt_d;
  logic [CHANNELS-1:0] reset_out_q, reset_out_d;
  logic                ready_q, ready_d;
  logic [4:0]          stage_q, stage_d;

  logic                lock_meta_q, lock_sync_q;
  logic [CHANNELS-1:0] req_meta_q, req_sync_q, req_prev_q;

  logic                req_any;
  logic [4:0]          req_idx;
  logic [CHANNELS-1:0] req_low;
  logic                event_inc;

  // Two-flop synchronisers for the asynchronous lock and request inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      req_meta_q  <= '0;
      req_sync_q  <= '0;
      req_prev_q  <= '0;
    end else begin
      lock_meta_q <= bus.locked;
      lock_sync_q <= lock_meta_q;
      req_meta_q  <= bus.request;
      req_sync_q  <= req_meta_q;
      req_prev_q  <= req_sync_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StHold;
      cnt_q       <= '0;
      filt_q      <= '0;
      reset_out_q <= '1;
      ready_q     <= 1'b0;
      stage_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      filt_q      <= filt_d;
      reset_out_q <= reset_out_d;
      ready_q     <= ready_d;
      stage_q     <= stage_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    filt_d      = filt_q;
    reset_out_d = reset_out_q;
    ready_d     = 1'b0;
    stage_d     = stage_q;
    event_inc   = 1'b0;

    req_any = |req_sync_q;
    req_idx = '0;
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      if (req_sync_q[i]) req_idx = 5'(i);
    end
    req_low = req_sync_q & (~req_sync_q + 1'b1);

    if (state_q != StHold && !lock_sync_q) begin
      state_d     = StHold;
      cnt_d       = '0;
      filt_d      = '0;
      reset_out_d = '1;
      stage_d     = '0;
      event_inc   = 1'b1;
    end else if (state_q != StHold && req_any && req_idx <= stage_q) begin
      // A request held at the current stage keeps the counter parked at zero.
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (5'(i) >= req_idx) reset_out_d[i] = 1'b1;
      end
      stage_d   = req_idx;
      cnt_d     = '0;
      state_d   = (req_idx == 5'd0) ? StInit : StStep;
      event_inc = |(req_low & ~req_prev_q);
    end else begin
      unique case (state_q)
        StHold: begin
          if (lock_sync_q) begin
            if (filt_q == FiltLast) begin
              state_d = StInit;
              cnt_d   = '0;
              filt_d  = '0;
            end else begin
              filt_d = filt_q + 1'b1;
            end
          end else begin
            filt_d = '0;
          end
        end
        StInit: begin
          if (cnt_q == InitLast) begin
            reset_out_d[0] = 1'b0;
            stage_d        = 5'd1;
            cnt_d          = '0;
            state_d        = (CHANNELS == 1) ? StRun : StStep;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StStep: begin
          if (cnt_q == StepLast) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
              if (5'(i) == stage_q) reset_out_d[i] = 1'b0;
            end
            stage_d = stage_q + 5'd1;
            cnt_d   = '0;
            if (stage_q == LastStg) state_d = StRun;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRun: begin
          ready_d = 1'b1;
        end
        default: begin
          state_d = StHold;
        end
      endcase
    end
  end

  assign bus.reset_out = reset_out_q;
  assign bus.ready     = ready_q;
  assign bus.stage     = stage_q;

`ifdef RESET_SEQ_EVENT_COUNT_EN
  logic [7:0] event_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_q <= '0;
    end else if (event_inc && event_q != 8'hFF) begin
      event_q <= event_q + 8'd1;
    end
  end

  assign bus.event_count = event_q;
`else
  logic unused_event;
  assign unused_event = event_inc;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: stimulus schedules expected output changes (edge number + value) from the
// timing rules; a negedge monitor pops and compares every observed output change.
module tb_reset_sequencer;

  localparam int CH      = 3;
  localparam int FreqHz  = 1000000;
  localparam int InitUs  = 20;
  localparam int StepUs  = 10;
  localparam int Lf      = 4;
  localparam int InitRaw = (FreqHz * InitUs) / 1000000;
  localparam int StepRaw = (FreqHz * StepUs) / 1000000;
  localparam int InitCyc = (InitRaw < 1) ? 1 : InitRaw;
  localparam int StepCyc = (StepRaw < 1) ? 1 : StepRaw;
  localparam logic [CH-1:0] AllOnes = '1;

  typedef struct {
    int            cyc;
    logic [CH-1:0] ro;
    logic          rdy;
    logic [4:0]    st;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  exp_t sched[$];
  int   idx    = 0;
  int   checks = 0;
  int   errors = 0;
  int   ev_exp = 0;

  reset_sequencer_if #(.CHANNELS(CH)) dif ();

  reset_sequencer #(
    .CLOCK_FREQUENCY (1.0e6),
    .CHANNELS        (CH),
    .INITIAL_DELAY_US(InitUs),
    .STEP_DELAY_US   (StepUs),
    .LOCK_FILTER     (Lf)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(dif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t last_state();
    exp_t e;
    if (sched.size() == 0) begin
      e.cyc = 0;
      e.ro  = AllOnes;
      e.rdy = 1'b0;
      e.st  = 5'd0;
    end else begin
      e = sched[sched.size() - 1];
    end
    return e;
  endfunction

  task automatic push(input int c, input logic [CH-1:0] ro, input logic rdy, input logic [4:0] st);
    exp_t l;
    exp_t e;
    l = last_state();
    if (l.ro === ro && l.rdy === rdy && l.st === st) return;
    e.cyc = c;
    e.ro  = ro;
    e.rdy = rdy;
    e.st  = st;
    sched.push_back(e);
  endtask

  // Forget scheduled changes that a disruption at edge c pre-empts.
  task automatic drop_from(input int c);
    while (sched.size() > idx && sched[sched.size() - 1].cyc >= c) void'(sched.pop_back());
  endtask

  // Sequencing resumes from stage s with its counter starting at zero after edge e.
  task automatic sched_release(input int e, input int s);
    int            t;
    logic [CH-1:0] ro;
    t = e + ((s == 0) ? InitCyc : StepCyc);
    for (int j = s; j < CH; j++) begin
      ro = AllOnes << (j + 1);
      push(t, ro, 1'b0, 5'(j + 1));
      if (j < CH - 1) t += StepCyc;
    end
    push(t + 1, '0, 1'b1, 5'(CH));
  endtask

  function automatic int lowest(input logic [CH-1:0] m);
    int r;
    r = CH;
    for (int i = CH - 1; i >= 0; i--) if (m[i]) r = i;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto_edge(input int e);
    while (cyc < e) tick(1);
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while (idx < sched.size() && b < 500) begin
      tick(1);
      b++;
    end
    tick(2);
    checks++;
    if (idx < sched.size()) begin
      errors++;
      $display("FAIL idle_timeout: %0d expected output changes not seen, next due at edge %0d",
               sched.size() - idx, sched[idx].cyc);
    end
  endtask

  // Monitor: every change of the output tuple must match the next scheduled change.
  logic [CH-1:0] prev_ro  = '1;
  logic          prev_rdy = 1'b0;
  logic [4:0]    prev_st  = 5'd0;

  always @(negedge clk) begin
    if (dif.reset_out !== prev_ro || dif.ready !== prev_rdy || dif.stage !== prev_st) begin
      checks++;
      if (idx >= sched.size()) begin
        errors++;
        $display("FAIL unexpected_change: edge %0d got ro=%b rdy=%b st=%0d, expected no change",
                 cyc, dif.reset_out, dif.ready, dif.stage);
      end else begin
        if (sched[idx].cyc != cyc || sched[idx].ro !== dif.reset_out ||
            sched[idx].rdy !== dif.ready || sched[idx].st !== dif.stage) begin
          errors++;
          $display("FAIL output_change: got edge %0d ro=%b rdy=%b st=%0d, expected edge %0d ro=%b rdy=%b st=%0d",
                   cyc, dif.reset_out, dif.ready, dif.stage,
                   sched[idx].cyc, sched[idx].ro, sched[idx].rdy, sched[idx].st);
        end
        idx++;
      end
      prev_ro  = dif.reset_out;
      prev_rdy = dif.ready;
      prev_st  = dif.stage;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at edge %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            n;
    int            p;
    int            k;
    int            t;
    int            r0;
    int            r1;
    logic [CH-1:0] mask;

    dif.locked  = 1'b1;
    dif.request = '0;
    rst         = 1'b1;
    tick(3);
    check("reset_out_in_reset", 32'(dif.reset_out), 32'(AllOnes));
    check("ready_in_reset", 32'(dif.ready), 32'd0);
    check("stage_in_reset", 32'(dif.stage), 32'd0);

    // Power-up release with lock already good.
    n   = cyc;
    rst = 1'b0;
    sched_release(n + 2 + Lf, 0);
    goto_edge(n + 1 + Lf);
    check("held_through_filter", 32'(dif.reset_out), 32'(AllOnes));
    wait_idle();
    check("ready_after_release", 32'(dif.ready), 32'd1);
    check("stage_after_release", 32'(dif.stage), 32'(CH));

    // Reset pulse, then a one-cycle lock glitch while the filter runs.
    n   = cyc;
    rst = 1'b1;
    drop_from(n + 1);
    push(n, AllOnes, 1'b0, 5'd0);
    tick(2);
    rst = 1'b0;
    n   = cyc;
    p   = $urandom_range(1, Lf - 1);
    goto_edge(n + p);
    dif.locked = 1'b0;
    tick(1);
    dif.locked = 1'b1;
    sched_release(n + p + 1 + 2 + Lf, 0);
    wait_idle();

    // Re-reset requests from RUN, lowest set index wins.
    for (int it = 0; it < 4; it++) begin
      case (it)
        0:       mask = 3'b010;
        1:       mask = 3'b101;
        default: mask = CH'($urandom_range(1, (1 << CH) - 1));
      endcase
      p = (it == 0) ? 5 : $urandom_range(1, 8);
      k = lowest(mask);
      n = cyc;
      dif.request = mask;
      drop_from(n + 3);
      push(n + 3, last_state().ro | (AllOnes << k), 1'b0, 5'(k));
      ev_exp++;
      tick(p);
      dif.request = '0;
      sched_release(n + p + 2, k);
      wait_idle();
    end
`ifdef RESET_SEQ_EVENT_COUNT_EN
    check("event_count_requests", 32'(dif.event_count), 32'(ev_exp));
`endif

    // Lock loss from RUN, then again while stage 2 is counting.
    n = cyc;
    dif.locked = 1'b0;
    drop_from(n + 3);
    push(n + 3, AllOnes, 1'b0, 5'd0);
    ev_exp++;
    tick($urandom_range(3, 6));
    dif.locked = 1'b1;
    n  = cyc;
    t  = n + 2 + Lf;
    sched_release(t, 0);
    r1 = t + InitCyc + StepCyc;
    p  = $urandom_range(1, StepCyc);
    goto_edge(r1 + p - 3);
    dif.locked = 1'b0;
    drop_from(r1 + p);
    push(r1 + p, AllOnes, 1'b0, 5'd0);
    ev_exp++;
    tick($urandom_range(3, 6));
    dif.locked = 1'b1;
    n = cyc;
`ifdef RESET_SEQ_EVENT_COUNT_EN
    check("event_count_lock_loss", 32'(dif.event_count), 32'(ev_exp));
`endif
    t = n + 2 + Lf;
    sched_release(t, 0);

    // Asynchronous reset between clock edges while stage 1 is counting.
    r0 = t + InitCyc;
    n  = r0 + $urandom_range(1, StepCyc - 1);
    goto_edge(n);
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_out", 32'(dif.reset_out), 32'(AllOnes));
    check("async_ready", 32'(dif.ready), 32'd0);
    check("async_stage", 32'(dif.stage), 32'd0);
`ifdef RESET_SEQ_EVENT_COUNT_EN
    check("async_event_count", 32'(dif.event_count), 32'd0);
`endif
    ev_exp = 0;
    drop_from(n + 1);
    push(n, AllOnes, 1'b0, 5'd0);
    tick(2);
    rst = 1'b0;
    n   = cyc;
    sched_release(n + 2 + Lf, 0);
    wait_idle();
    check("final_ready", 32'(dif.ready), 32'd1);
    check("final_stage", 32'(dif.stage), 32'(CH));
`ifdef RESET_SEQ_EVENT_COUNT_EN
    check("final_event_count", 32'(dif.event_count), 32'(ev_exp));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
